// File: rtl/ide_host_pkg.sv
// Shared types and constants for the ATA/IDE PIO host initiator.
package ide_host_pkg;

  // Width of the phase and iordy-extension counters.
  localparam int CNT_W   = 8;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  // Bus sequencing states.
  typedef enum logic [2:0] {
    BUSRST,
    IDLE,
    SETUP,
    ACTIVE,
    HOLD,
    DONE
  } state_e;

  // Command block registers (selected with cs1fx_).
  localparam logic [2:0] REG_DATA     = 3'd0;
  localparam logic [2:0] REG_ERROR    = 3'd1;
  localparam logic [2:0] REG_FEATURES = 3'd1;
  localparam logic [2:0] REG_SECCNT   = 3'd2;
  localparam logic [2:0] REG_SECNR    = 3'd3;
  localparam logic [2:0] REG_CYLLO    = 3'd4;
  localparam logic [2:0] REG_CYLHI    = 3'd5;
  localparam logic [2:0] REG_DRVHEAD  = 3'd6;
  localparam logic [2:0] REG_STATUS   = 3'd7;
  localparam logic [2:0] REG_COMMAND  = 3'd7;

  // Control block registers (selected with cs3fx_).
  localparam logic [2:0] REG_ALTSTATUS = 3'd6;
  localparam logic [2:0] REG_DEVCTRL   = 3'd6;

endpackage

// File: rtl/ide_host_sync.sv
// Two-flop synchronizer for asynchronous IDE bus inputs (iordy, intrq).
module ide_host_sync (
  input  logic clk,
  input  logic reset_,
  input  logic d,
  output logic q
);

  logic meta;

  // Shift the input through two flops; both clear to 0 on reset.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make both flops sample together, giving a true two-stage delay.
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/ide_host_master.sv
// ATA/IDE PIO host initiator: turns single register read/write requests
// into timed da/cs/strobe/data bus cycles, honours iordy with a timeout,
// drives the bus hardware reset and synchronizes intrq.
module ide_host_master
  import ide_host_pkg::*;
#(
  parameter int T_SETUP       = 2,
  parameter int T_ACTIVE      = 4,
  parameter int T_RECOVER     = 2,
  parameter int IORDY_TIMEOUT = 64,
  parameter int RESET_CYCLES  = 16
) (
  input  logic        clk,
  input  logic        reset_,
  // Request side
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic        req_ctrl,
  input  logic [2:0]  req_addr,
  input  logic [15:0] req_wdata,
  // Response side
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_timeout,
  input  logic        host_rst_req,
  output logic        irq,
  // IDE bus
  output logic [2:0]  da,
  output logic        cs1fx_,
  output logic        cs3fx_,
  output logic        dior_,
  output logic        diow_,
  output logic [15:0] dd_out,
  output logic        dd_oe,
  input  logic [15:0] dd_in,
  input  logic        iordy,
  input  logic        intrq,
  output logic        ide_reset_
);

  // Every timing parameter must fit the 8-bit counters and be at least 1.
  if (T_SETUP < 1 || T_SETUP > CNT_MAX ||
      T_ACTIVE < 1 || T_ACTIVE > CNT_MAX ||
      T_RECOVER < 1 || T_RECOVER > CNT_MAX ||
      IORDY_TIMEOUT < 1 || IORDY_TIMEOUT > CNT_MAX ||
      RESET_CYCLES < 1 || RESET_CYCLES > CNT_MAX) begin : g_param_check
    $error("ide_host_master: timing parameters must lie in 1..255");
  end

  // Terminal counts, one less than the phase length because counting starts at 0.
  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] ACTIVE_LAST  = CNT_W'(T_ACTIVE - 1);
  localparam logic [CNT_W-1:0] RECOVER_LAST = CNT_W'(T_RECOVER - 1);
  localparam logic [CNT_W-1:0] RESET_LAST   = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] EXT_LIMIT    = CNT_W'(IORDY_TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

  state_e           state;
  logic [CNT_W-1:0] cnt;        // cycles spent in the current phase
  logic [CNT_W-1:0] ext;        // strobe-low cycles added while waiting on iordy
  logic             lat_write;  // direction of the transfer in flight
  logic             to_flag;    // iordy timeout seen on the transfer in flight
  logic             iordy_s;

  ide_host_sync u_sync_iordy (
    .clk    (clk),
    .reset_ (reset_),
    .d      (iordy),
    .q      (iordy_s)
  );

  ide_host_sync u_sync_intrq (
    .clk    (clk),
    .reset_ (reset_),
    .d      (intrq),
    .q      (irq)
  );

  // Bus sequencer: state, counters and every registered bus/response output.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state       <= BUSRST;
      cnt         <= '0;
      ext         <= '0;
      lat_write   <= 1'b0;
      to_flag     <= 1'b0;
      ide_reset_  <= 1'b0;
      cs1fx_      <= 1'b1;
      cs3fx_      <= 1'b1;
      dior_       <= 1'b1;
      diow_       <= 1'b1;
      da          <= '0;
      dd_oe       <= 1'b0;
      dd_out      <= '0;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= '0;
    end else begin
      // Response flags are single-cycle; only the HOLD exit raises them.
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;

      case (state)
        BUSRST: begin
          if (cnt == RESET_LAST) begin
            cnt        <= '0;
            ide_reset_ <= 1'b1;
            req_ready  <= 1'b1;
            state      <= IDLE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        IDLE: begin
          // A request wins over a simultaneous bus reset request, which is dropped.
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            lat_write <= req_write;
            da        <= req_addr;
            cs1fx_    <= req_ctrl;
            cs3fx_    <= ~req_ctrl;
            if (req_write) begin
              dd_out <= req_wdata;
              dd_oe  <= 1'b1;
            end
            cnt   <= '0;
            ext   <= '0;
            state <= SETUP;
          end else if (host_rst_req) begin
            req_ready  <= 1'b0;
            ide_reset_ <= 1'b0;
            cnt        <= '0;
            state      <= BUSRST;
          end
        end

        SETUP: begin
          if (cnt == SETUP_LAST) begin
            cnt <= '0;
            if (lat_write) diow_ <= 1'b0;
            else           dior_ <= 1'b0;
            state <= ACTIVE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        ACTIVE: begin
          if (cnt != ACTIVE_LAST) begin
            cnt <= cnt + CNT_ONE;
          end else if (iordy_s || ext == EXT_LIMIT) begin
            // Strobe rises on this edge, so read data is sampled on the same edge.
            dior_ <= 1'b1;
            diow_ <= 1'b1;
            if (!lat_write) rsp_rdata <= dd_in;
            to_flag <= ~iordy_s;
            cnt     <= '0;
            state   <= HOLD;
          end else begin
            ext <= ext + CNT_ONE;
          end
        end

        HOLD: begin
          if (cnt == RECOVER_LAST) begin
            cs1fx_      <= 1'b1;
            cs3fx_      <= 1'b1;
            dd_oe       <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_timeout <= to_flag;
            to_flag     <= 1'b0;
            cnt         <= '0;
            state       <= DONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        DONE: begin
          req_ready <= 1'b1;
          state     <= IDLE;
        end

        default: begin
          state <= BUSRST;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ide_host_master.sv
// Self-checking bench for ide_host_master: directed and randomized PIO
// transfers compared cycle-by-cycle against a timing model built from the
// bus rules (setup/active/recover lengths, iordy extension, timeout).
module tb_ide_host_master;
  import ide_host_pkg::*;

  localparam int T_SETUP       = 2;
  localparam int T_ACTIVE      = 4;
  localparam int T_RECOVER     = 2;
  localparam int IORDY_TIMEOUT = 64;
  localparam int RESET_CYCLES  = 16;
  localparam int SYNC_LAT      = 2;  // flops in the iordy synchronizer

  logic        clk = 1'b0;
  logic        reset_ = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic        req_ctrl = 1'b0;
  logic [2:0]  req_addr = '0;
  logic [15:0] req_wdata = '0;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        rsp_timeout;
  logic        host_rst_req = 1'b0;
  logic        irq;
  logic [2:0]  da;
  logic        cs1fx_, cs3fx_, dior_, diow_;
  logic [15:0] dd_out;
  logic        dd_oe;
  logic [15:0] dd_in = '0;
  logic        iordy = 1'b1;
  logic        intrq = 1'b0;
  logic        ide_reset_;

  int n_checks = 0;
  int n_pass   = 0;
  logic [15:0] exp_rdata = '0;  // model of the rsp_rdata holding register

  ide_host_master #(
    .T_SETUP       (T_SETUP),
    .T_ACTIVE      (T_ACTIVE),
    .T_RECOVER     (T_RECOVER),
    .IORDY_TIMEOUT (IORDY_TIMEOUT),
    .RESET_CYCLES  (RESET_CYCLES)
  ) dut (
    .clk          (clk),
    .reset_       (reset_),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_ctrl     (req_ctrl),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_rdata    (rsp_rdata),
    .rsp_timeout  (rsp_timeout),
    .host_rst_req (host_rst_req),
    .irq          (irq),
    .da           (da),
    .cs1fx_       (cs1fx_),
    .cs3fx_       (cs3fx_),
    .dior_        (dior_),
    .diow_        (diow_),
    .dd_out       (dd_out),
    .dd_oe        (dd_oe),
    .dd_in        (dd_in),
    .iordy        (iordy),
    .intrq        (intrq),
    .ide_reset_   (ide_reset_)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Bit mask with ones at cycle indices lo..hi.
  function automatic logic [127:0] mk(input int lo, input int hi);
    logic [127:0] r = '0;
    for (int i = lo; i <= hi; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Count cycles ide_reset_ stays low, starting with the current cycle.
  task automatic count_bus_reset(output int n, output bit rv_seen);
    n = 0;
    rv_seen = 1'b0;
    while (ide_reset_ === 1'b0 && n < 100) begin
      if (rsp_valid === 1'b1) rv_seen = 1'b1;
      n++;
      @(negedge clk);
    end
  endtask

  // One PIO transfer. hold < 0: iordy stays high. hold >= 0: iordy is low
  // before the strobe falls and rises 'hold' cycles after it falls.
  task automatic do_txn(input string tag, input bit wr, input bit ctrl,
                        input logic [2:0] addr, input logic [15:0] wdata,
                        input int hold, input bit rand_dd,
                        input logic [15:0] dd_fix, input bit with_rst);
    int L, last, n, fall_k;
    bit exp_to, fell, da_bad, dd_bad, rst_seen, rsp_to;
    logic [15:0] rsp_rd, captured;
    logic [127:0] o_cs, o_csx, o_stb, o_stbx, o_oe, o_rv, o_rdy;
    o_cs = '0; o_csx = '0; o_stb = '0; o_stbx = '0; o_oe = '0; o_rv = '0; o_rdy = '0;
    fell = 0; fall_k = 0; da_bad = 0; dd_bad = 0; rst_seen = 0; rsp_to = 0;
    rsp_rd = 'x;
    iordy = (hold < 0);
    dd_in = dd_fix;
    captured = dd_fix;
    repeat (SYNC_LAT + 1) @(negedge clk);

    // Expected strobe-low length from the iordy rules.
    exp_to = 0;
    if (hold < 0) L = T_ACTIVE;
    else L = (hold + SYNC_LAT + 1 > T_ACTIVE) ? hold + SYNC_LAT + 1 : T_ACTIVE;
    if (L > T_ACTIVE + IORDY_TIMEOUT) begin
      L = T_ACTIVE + IORDY_TIMEOUT;
      exp_to = 1;
    end
    last = T_SETUP + L + T_RECOVER + 2;

    n = 0;
    while (req_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready_before"}, req_ready, 1'b1);

    req_valid = 1'b1; req_write = wr; req_ctrl = ctrl;
    req_addr = addr; req_wdata = wdata; host_rst_req = with_rst;
    @(negedge clk);
    req_valid = 1'b0; host_rst_req = 1'b0;
    req_addr = ~addr; req_wdata = 16'($urandom);

    for (int k = 1; k <= last; k++) begin
      o_cs[k]   = ctrl ? !cs3fx_ : !cs1fx_;
      o_csx[k]  = ctrl ? !cs1fx_ : !cs3fx_;
      o_stb[k]  = wr ? !diow_ : !dior_;
      o_stbx[k] = wr ? !dior_ : !diow_;
      o_oe[k]   = dd_oe;
      o_rv[k]   = rsp_valid;
      o_rdy[k]  = req_ready;
      if (o_cs[k] && da !== addr) da_bad = 1;
      if (dd_oe === 1'b1 && dd_out !== wdata) dd_bad = 1;
      if (ide_reset_ !== 1'b1) rst_seen = 1;
      if (rsp_valid === 1'b1) begin
        rsp_to = rsp_timeout;
        rsp_rd = rsp_rdata;
      end
      if (o_stb[k]) begin
        if (!fell) begin
          fell = 1;
          fall_k = k;
        end
        if (rand_dd) dd_in = 16'($urandom);
        captured = dd_in;
      end
      if (hold >= 0 && fell && k == fall_k + hold) iordy = 1'b1;
      @(negedge clk);
    end

    if (!wr) exp_rdata = captured;
    check({tag, " cs"},        o_cs,   mk(1, T_SETUP + L + T_RECOVER));
    check({tag, " other_cs"},  o_csx,  '0);
    check({tag, " strobe"},    o_stb,  mk(T_SETUP + 1, T_SETUP + L));
    check({tag, " other_stb"}, o_stbx, '0);
    check({tag, " dd_oe"},     o_oe,   wr ? mk(1, T_SETUP + L + T_RECOVER) : '0);
    check({tag, " rsp_valid"}, o_rv,   mk(last - 1, last - 1));
    check({tag, " req_ready"}, o_rdy,  mk(last, last));
    check({tag, " da"},        da_bad, 1'b0);
    check({tag, " dd_out"},    dd_bad, 1'b0);
    check({tag, " no_busrst"}, rst_seen, 1'b0);
    check({tag, " timeout"},   rsp_to, exp_to);
    check({tag, " rdata"},     rsp_rd, exp_rdata);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  n;
    bit  rv_seen;
    int  hold;
    bit  wr;

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst ide_reset_", ide_reset_, 1'b0);
    check("rst bus_idle", {cs1fx_, cs3fx_, dior_, diow_}, 4'b1111);
    check("rst da_dd", {da, dd_oe, dd_out}, '0);
    check("rst rsp", {req_ready, rsp_valid, rsp_timeout, rsp_rdata, irq}, '0);

    // Power-on bus reset length.
    reset_ = 1'b1;
    count_bus_reset(n, rv_seen);
    check("por_len", n, RESET_CYCLES);
    check("por_ready", req_ready, 1'b1);

    // Host-requested bus reset from IDLE.
    host_rst_req = 1'b1;
    @(negedge clk);
    host_rst_req = 1'b0;
    count_bus_reset(n, rv_seen);
    check("hostrst_len", n, RESET_CYCLES);
    check("hostrst_ready", req_ready, 1'b1);

    // Directed transfers.
    do_txn("wr_cmd7", 1'b1, 1'b0, REG_COMMAND, 16'h00A0, -1, 1'b0, 16'h1234, 1'b0);
    do_txn("rd_ctrl6", 1'b0, 1'b1, REG_ALTSTATUS, 16'h0000, -1, 1'b0, 16'h0050, 1'b0);
    do_txn("rd_wait10", 1'b0, 1'b0, REG_STATUS, 16'h0000, 10, 1'b1, 16'h0000, 1'b0);
    do_txn("rd_stuck", 1'b0, 1'b0, REG_DATA, 16'h0000, 1000, 1'b1, 16'h0000, 1'b0);
    do_txn("wr_after_to", 1'b1, 1'b0, REG_SECCNT, 16'h0055, -1, 1'b0, 16'h0000, 1'b0);
    do_txn("wr_stuck", 1'b1, 1'b1, REG_DEVCTRL, 16'h0004, 1000, 1'b0, 16'h0000, 1'b0);
    do_txn("wr_prio", 1'b1, 1'b0, REG_DRVHEAD, 16'h00E0, -1, 1'b0, 16'h0000, 1'b1);

    // Randomized transfers.
    for (int i = 0; i < 10; i++) begin
      wr   = 1'($urandom);
      hold = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 20));
      do_txn($sformatf("rand%0d", i), wr, 1'($urandom), 3'($urandom),
             16'($urandom), hold, 1'b1, 16'($urandom), 1'b0);
    end

    // Reset asserted in the middle of a write strobe.
    iordy = 1'b0;
    repeat (SYNC_LAT + 1) @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_ctrl = 1'b0;
    req_addr = REG_DATA; req_wdata = 16'hBEEF;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (diow_ !== 1'b0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort strobe_low_seen", diow_, 1'b0);
    intrq = 1'b1;
    reset_ = 1'b0;
    #1;
    check("abort strobes_high", {dior_, diow_, cs1fx_, cs3fx_}, 4'b1111);
    check("abort dd_oe", dd_oe, 1'b0);
    check("abort ide_reset_", ide_reset_, 1'b0);
    rv_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (rsp_valid === 1'b1) rv_seen = 1'b1;
    end
    check("abort irq_held_in_reset", irq, 1'b0);
    intrq = 1'b0;
    iordy = 1'b1;
    exp_rdata = '0;
    reset_ = 1'b1;
    count_bus_reset(n, rv_seen);
    check("abort busrst_len", n, RESET_CYCLES);
    check("abort no_rsp", rv_seen, 1'b0);
    check("abort rdata_cleared", rsp_rdata, exp_rdata);

    // intrq synchronization while a bus reset is running.
    host_rst_req = 1'b1;
    @(negedge clk);
    host_rst_req = 1'b0;
    intrq = 1'b1;
    @(negedge clk);
    check("irq rise+1", irq, 1'b0);
    @(negedge clk);
    check("irq rise+2", irq, 1'b1);
    intrq = 1'b0;
    @(negedge clk);
    check("irq fall+1", irq, 1'b1);
    @(negedge clk);
    check("irq fall+2", irq, 1'b0);
    check("irq in_busrst", ide_reset_, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ide_host_master.md
Name: ide_host_master

Overview:
- PIO initiator for the ATA/IDE bus; the host-side counterpart of the device-side register interface.
- Accepts single register read/write requests from a local controller (test harness or host CPU bridge).
- Sequences da/cs1fx_/cs3fx_/dior_/diow_/dd with programmable setup, active and recovery timing, honouring iordy with a timeout.
- Drives the bus hardware reset (ide_reset_) and presents a synchronized intrq to the controller.

Parameters:
- T_SETUP, 2: cycles address/chip-select are valid before the strobe falls; minimum 1.
- T_ACTIVE, 4: minimum strobe-low cycles; minimum 1.
- T_RECOVER, 2: cycles address/cs/data are held after the strobe rises; minimum 1.
- IORDY_TIMEOUT, 64: maximum extra strobe-low cycles while iordy is low.
- RESET_CYCLES, 16: ide_reset_ low time, in cycles.

Ports:
- clk  in  1  system clock
- reset_  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1=write, 0=read
- req_ctrl  in  1  1=control block (cs3fx_), 0=command block (cs1fx_)
- req_addr  in  3  register address
- req_wdata  in  16  write data
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  16  captured read data; held until the next capture
- rsp_timeout  out  1  qualifies rsp_valid: iordy timeout occurred
- host_rst_req  in  1  request a bus hardware reset (sampled only in IDLE)
- irq  out  1  intrq after a 2-flop synchronizer
- da  out  3  IDE address
- cs1fx_, cs3fx_  out  1 each  IDE chip selects, active low
- dior_, diow_  out  1 each  IDE strobes, active low
- dd_out  out  16  IDE data out
- dd_oe  out  1  IDE data output enable
- dd_in  in  16  IDE data in
- iordy  in  1  IDE ready; 2-flop synchronized internally
- intrq  in  1  IDE interrupt
- ide_reset_  out  1  IDE hardware reset, active low

Behaviour:
- Clocking and reset: one clock (clk); reset_ is asynchronous and active-low.
- Reset values: state=BUSRST, counter=0, ide_reset_=0, cs1fx_=cs3fx_=dior_=diow_=1, da=0, dd_oe=0, dd_out=0, req_ready=0, rsp_valid=0, rsp_timeout=0, rsp_rdata=0, irq=0.
- All bus outputs are registered; no combinational path from request inputs to the pins.
- States: BUSRST, IDLE, SETUP, ACTIVE, HOLD, DONE.
- BUSRST:
  - ide_reset_=0 for RESET_CYCLES cycles, then IDLE with ide_reset_=1.
  - Entered after reset_ release, or from IDLE when host_rst_req=1 and no request is being accepted.
- IDLE:
  - req_ready=1.
  - On req_valid&req_ready: latch write, ctrl, addr, wdata; go to SETUP.
  - req_valid has priority over a simultaneous host_rst_req; the reset request is dropped.
- SETUP (T_SETUP cycles):
  - da=addr; cs1fx_=ctrl; cs3fx_=~ctrl; strobes high.
  - For writes: dd_out=wdata and dd_oe=1.
- ACTIVE:
  - dior_ (read) or diow_ (write) is low; da, cs and dd hold their values.
  - After T_ACTIVE cycles: if the synchronized iordy=1, go to HOLD.
  - Otherwise extend one cycle at a time. If the extension count reaches IORDY_TIMEOUT, set the timeout flag and go to HOLD.
  - Read data is captured into rsp_rdata from dd_in on the edge that leaves ACTIVE (the same edge the strobe rises).
- HOLD (T_RECOVER cycles): strobe high; da, cs and write data still driven; then DONE.
- DONE (one cycle):
  - cs1fx_=cs3fx_=1; dd_oe=0; da retains its value.
  - rsp_valid=1; rsp_timeout=flag; flag cleared.
  - Next state IDLE.
- Latency with defaults and no wait:
  - Accept edge at cycle 0; SETUP in cycles 1–2, ACTIVE in cycles 3–6, HOLD in cycles 7–8, rsp_valid in cycle 9.
  - req_ready is high again in cycle 10.
- Width: counters are 8 bits. The parameter range 1..255 is enforced by an elaboration-time check.
- Writes drive the full 16 bits. Callers place 8-bit register values in [7:0].
- irq tracks intrq through the synchronizer in every state, including BUSRST.
- reset_ asserted mid-cycle: strobes and chip selects rise immediately (asynchronous); no rsp_valid is produced for the aborted request.

Decomposition:
- Package ide_host_pkg holds:
  - the state enum;
  - register address constants: DATA=0, ERROR/FEATURES=1, SECCNT=2, SECNR=3, CYLLO=4, CYLHI=5, DRVHEAD=6, STATUS/COMMAND=7, with ALTSTATUS/DEVCTRL = ctrl block address 6;
  - the counter width constant.
- One sub-module: ide_host_sync, a 2-flop synchronizer with async active-low reset to 0, instantiated for iordy and intrq.

Test Plan:
- Release reset_: ide_reset_ low exactly 16 cycles, then req_ready=1. A host_rst_req pulse in IDLE repeats the 16-cycle reset.
- Write cmd addr 7, wdata 16'h00A0, iordy=1:
  - cs1fx_=0 and da=7 for 8 cycles; diow_ low exactly cycles 3–6; dd_oe=1 cycles 1–8.
  - rsp_valid in cycle 9 with rsp_timeout=0.
- Read ctrl addr 6 with dd_in=16'h0050: cs3fx_=0, dior_ low 4 cycles, rsp_rdata=16'h0050 at rsp_valid, dd_oe never 1.
- Read with iordy held low 10 cycles after the strobe falls: dior_ low 4+ extension cycles; rsp_timeout=0; data sampled at the rising strobe.
- iordy stuck low: strobe low exactly T_ACTIVE+64 cycles, then rsp_valid with rsp_timeout=1. The next request completes normally with rsp_timeout=0.
- Assert reset_ during ACTIVE of a write: dior_/diow_/cs go high asynchronously, dd_oe=0, no rsp_valid, BUSRST sequence restarts. Toggle intrq: irq follows after 2 cycles.
